imem_prog: RTL
==============

# imem_prog

Parametrised, loadable instruction memory for the LEGv8 datapath, replacing the fixed-content ROM at the fetch stage. It has a registered single-cycle fetch port with a request/valid handshake. A streaming program-load port writes a new program word by word, without re-elaboration. An optional zero-fill pass clears every word above the last loaded one.

## Interface
Parameters:
- `N`, 32: instruction word width in bits.
- `DEPTH`, 64: number of words; any value ≥ 2, not necessarily a power of two.
- `AW`, `$clog2(DEPTH)`: address width.

Ports:
- `clk` in 1: single clock; all state changes on its rising edge.
- `reset` in 1: asynchronous, active-low.
- `fetch_req` in 1: fetch request; sampled only in IDLE.
- `addr` in AW: word address for the fetch.
- `q` out N: fetched instruction, registered.
- `q_valid` out 1: `q` updated this cycle.
- `ld_start` in 1: begin a program load; sampled only in IDLE.
- `ld_word` in N: program word.
- `ld_valid` in 1: `ld_word` valid.
- `ld_last` in 1: qualifies `ld_word` as the final word.
- `ld_ready` out 1: loader accepts a word this cycle.
- `ld_done` out 1: one-cycle pulse when the load completes.
- `ld_count` out AW+1: number of host words written by the last load.
- `busy` out 1: state is not IDLE.

## Operation
- States: IDLE, LOAD, FILL.
- Internal write pointer `ptr` (AW+1 bits).
- Memory array is initialised to all zeros at elaboration. Reset does not clear it.
- **IDLE**
  - `ld_start` = 1: go to LOAD, set `ptr` = 0 and `ld_count` = 0. A fetch request in the same cycle is ignored.
  - Otherwise, `fetch_req` = 1: next cycle `q` = `ROM[addr]` and `q_valid` = 1.
  - If `addr` ≥ DEPTH, the fetch returns 0 with `q_valid` = 1.
- **LOAD**
  - `ld_ready` = 1.
  - On `ld_valid`: write `ROM[ptr]` = `ld_word`, then increment `ptr` and `ld_count`.
  - Transfer with `ld_last` = 1, or the write at `ptr` = DEPTH-1: go to FILL if `ptr`+1 < DEPTH, else go to IDLE with `ld_done`.
  - `ld_start` and `fetch_req` are ignored.
- **FILL**
  - `ld_ready` = 0.
  - Writes 0 to `ROM[ptr]` each cycle and increments `ptr`.
  - After writing DEPTH-1, go to IDLE and pulse `ld_done` in that same cycle.
- Outside IDLE, `q_valid` = 0 and `q` holds its last value.
- In IDLE with no request, `q` holds and `q_valid` = 0.
- `ld_count` holds until the next `ld_start`.

## Timing
- Reset values: `q` = 0, `q_valid` = 0, `ld_ready` = 0, `ld_done` = 0, `ld_count` = 0, `busy` = 0, state = IDLE, `ptr` = 0.
- Fetch latency is 1 cycle. Back-to-back requests give one result per cycle.
- Read-after-load: a fetch issued in the cycle after `ld_done` returns the new contents.
- Load throughput is one word per cycle. `ld_ready` is high in the cycle LOAD is entered.
- FILL lasts DEPTH − `ld_count` cycles.
- `ld_done` is high for exactly 1 cycle. `busy` falls in the same cycle.
- A transfer with `ld_valid` = 1 while `ld_ready` = 0 is dropped.
- Reset mid-LOAD or mid-FILL: the next edge is not needed; state returns to IDLE and `ld_count` = 0. Words already written are retained. No `ld_done` is issued.

## Configuration
- `IMEM_ZERO_FILL_EN`
  - Defined: FILL state exists and behaves as above.
  - Undefined: FILL is compiled out. End of LOAD goes straight to IDLE with `ld_done`. Words above the last loaded one keep their previous contents.

## Test plan
- Reset, then fetch `addr` = 0..63 back-to-back → `q_valid` = 1 on each of 64 consecutive cycles, all `q` = 0.
- Load 3 words 0xf8000001, 0xf8008002, 0xcb050083, last one flagged `ld_last` → `ld_count` = 3. With zero fill: FILL runs 61 cycles, `ld_done` arrives at cycle 64 after the first transfer, and fetches of 0/1/2/3 return those three words then 0.
- Load 64 words with no `ld_last` → no FILL, `ld_done` in the cycle after the 64th transfer. A 65th `ld_valid` is ignored (`ld_ready` = 0). Fetch 63 returns word 63.
- Preload all words 0xffffffff, build without `IMEM_ZERO_FILL_EN`, load 2 words → fetch 2 returns 0xffffffff. With the macro defined → fetch 2 returns 0.
- Assert `fetch_req` during LOAD → `q_valid` stays 0 and `q` holds. Assert `ld_start` and `fetch_req` in the same IDLE cycle → load starts and no fetch result appears.
- Assert reset after 5 words of a load → immediately `busy` = 0 and `ld_count` = 0, no `ld_done`. Fetch 4 returns the 5th word.
- DEPTH = 48: fetch `addr` = 50 → `q` = 0, `q_valid` = 1.

Source files
------------

// File: rtl/imem_prog.sv
// rtl/imem_prog.sv - loadable LEGv8 instruction memory with registered fetch port, streaming loader and optional zero fill (IMEM_ZERO_FILL_EN)
module imem_prog #(
    parameter int N     = 32,
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          fetch_req,
    input  logic [AW-1:0] addr,
    output logic [N-1:0]  q,
    output logic          q_valid,
    input  logic          ld_start,
    input  logic [N-1:0]  ld_word,
    input  logic          ld_valid,
    input  logic          ld_last,
    output logic          ld_ready,
    output logic          ld_done,
    output logic [AW:0]   ld_count,
    output logic          busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        FILL = 2'd2
    } state_e;

    localparam logic [AW:0] DEPTH_W  = (AW+1)'(DEPTH);
    localparam logic [AW:0] LAST_PTR = (AW+1)'(DEPTH - 1);

    // Program storage starts cleared and is deliberately left alone by reset.
    logic [N-1:0] mem_q [DEPTH] = '{default: '0};

    state_e        state_q;
    logic [AW:0]   ptr_q;
    logic [N-1:0]  q_q;
    logic          q_valid_q;
    logic          ld_ready_q;
    logic          ld_done_q;
    logic [AW:0]   ld_count_q;
    logic          busy_q;

    logic          mem_we;
    logic [N-1:0]  mem_wdata;
    logic          addr_ok;

    assign addr_ok  = ({1'b0, addr} < DEPTH_W);

    assign q        = q_q;
    assign q_valid  = q_valid_q;
    assign ld_ready = ld_ready_q;
    assign ld_done  = ld_done_q;
    assign ld_count = ld_count_q;
    assign busy     = busy_q;

    // Write port select: accepted host words while loading, zeros while filling.
    always_comb begin
        mem_we    = 1'b0;
        mem_wdata = ld_word;
        if (state_q == LOAD && ld_valid) begin
            mem_we = 1'b1;
        end
`ifdef IMEM_ZERO_FILL_EN
        if (state_q == FILL) begin
            mem_we    = 1'b1;
            mem_wdata = '0;
        end
`endif
    end

    // Single write port, addressed by the load/fill pointer.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[ptr_q[AW-1:0]] <= mem_wdata;
        end
    end

    // Control FSM with registered fetch result and loader status outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            q_q        <= '0;
            q_valid_q  <= 1'b0;
            ld_ready_q <= 1'b0;
            ld_done_q  <= 1'b0;
            ld_count_q <= '0;
            busy_q     <= 1'b0;
        end else begin
            q_valid_q <= 1'b0;
            ld_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (ld_start) begin
                        // A load start wins over a fetch in the same cycle.
                        state_q    <= LOAD;
                        ptr_q      <= '0;
                        ld_count_q <= '0;
                        ld_ready_q <= 1'b1;
                        busy_q     <= 1'b1;
                    end else if (fetch_req) begin
                        q_valid_q <= 1'b1;
                        q_q       <= addr_ok ? mem_q[addr] : '0;
                    end
                end
                LOAD: begin
                    if (ld_valid) begin
                        ptr_q      <= ptr_q + 1'b1;
                        ld_count_q <= ld_count_q + 1'b1;
                        if (ld_last || ptr_q == LAST_PTR) begin
                            ld_ready_q <= 1'b0;
`ifdef IMEM_ZERO_FILL_EN
                            if (ptr_q != LAST_PTR) begin
                                state_q <= FILL;
                            end else begin
                                state_q   <= IDLE;
                                busy_q    <= 1'b0;
                                ld_done_q <= 1'b1;
                            end
`else
                            state_q   <= IDLE;
                            busy_q    <= 1'b0;
                            ld_done_q <= 1'b1;
`endif
                        end
                    end
                end
`ifdef IMEM_ZERO_FILL_EN
                FILL: begin
                    ptr_q <= ptr_q + 1'b1;
                    if (ptr_q == LAST_PTR) begin
                        state_q   <= IDLE;
                        busy_q    <= 1'b0;
                        ld_done_q <= 1'b1;
                    end
                end
`endif
                default: begin
                    state_q    <= IDLE;
                    ld_ready_q <= 1'b0;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

endmodule
